// File: rtl/pcie_mm_master.sv
// pcie_mm_master: PCIe request to single-outstanding MM bus bridge with read timeout
module pcie_mm_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iREQ_V,
  output logic        oREQ_RDY,
  input  logic        iREQ_WR,
  input  logic [16:0] iREQ_ADDR,
  input  logic [63:0] iREQ_DATA,
  input  logic [7:0]  iREQ_TAG,
  output logic        oCPL_V,
  input  logic        iCPL_RDY,
  output logic [63:0] oCPL_DATA,
  output logic [7:0]  oCPL_TAG,
  output logic        oCPL_TIMEOUT,
  output logic [16:0] oMM_ADDR,
  output logic        oMM_WR_EN,
  output logic        oMM_RD_EN,
  output logic [63:0] oMM_WR_DATA,
  input  logic [63:0] iMM_RD_DATA,
  input  logic        iMM_RD_DATA_V,
  output logic [15:0] oTIMEOUT_CNT
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, CPL = 2'd3;
  logic [1:0]  state;
  logic        wr_q;
  logic [7:0]  tag_q;
  logic [15:0] wait_cnt;
  assign oREQ_RDY = rst_n && state == IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      tag_q        <= '0;
      wait_cnt     <= '0;
      oCPL_V       <= 1'b0;
      oCPL_DATA    <= '0;
      oCPL_TAG     <= '0;
      oCPL_TIMEOUT <= 1'b0;
      oMM_ADDR     <= '0;
      oMM_WR_DATA  <= '0;
      oMM_WR_EN    <= 1'b0;
      oMM_RD_EN    <= 1'b0;
      oTIMEOUT_CNT <= '0;
    end else begin
      oMM_WR_EN <= 1'b0;
      oMM_RD_EN <= 1'b0;
      case (state)
        IDLE: if (iREQ_V) begin
          state       <= ISSUE;
          wr_q        <= iREQ_WR;
          tag_q       <= iREQ_TAG;
          oMM_ADDR    <= iREQ_ADDR;
          oMM_WR_DATA <= iREQ_DATA;
          oMM_WR_EN   <= iREQ_WR;
          oMM_RD_EN   <= !iREQ_WR;
        end
        ISSUE: begin
          state    <= wr_q ? IDLE : WAIT_RD;
          wait_cnt <= '0;
        end
        WAIT_RD: if (iMM_RD_DATA_V) begin
          state        <= CPL;
          oCPL_V       <= 1'b1;
          oCPL_DATA    <= iMM_RD_DATA;
          oCPL_TAG     <= tag_q;
          oCPL_TIMEOUT <= 1'b0;
        end else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state        <= CPL;
          oCPL_V       <= 1'b1;
          oCPL_DATA    <= 64'hDEAD_BEEF_DEAD_BEEF;
          oCPL_TAG     <= tag_q;
          oCPL_TIMEOUT <= 1'b1;
          oTIMEOUT_CNT <= oTIMEOUT_CNT + {15'd0, oTIMEOUT_CNT != 16'hFFFF};
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
        default: if (iCPL_RDY) begin
          state  <= IDLE;
          oCPL_V <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pcie_mm_master.sv
// tb_pcie_mm_master: directed stimulus with queue scoreboards for MM strobes and completions
module tb_pcie_mm_master;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        iREQ_V = 1'b0, iREQ_WR = 1'b0, iCPL_RDY = 1'b1, iMM_RD_DATA_V = 1'b0;
  logic [16:0] iREQ_ADDR = '0;
  logic [63:0] iREQ_DATA = '0, iMM_RD_DATA = '0;
  logic [7:0]  iREQ_TAG = '0;
  logic        oREQ_RDY, oCPL_V, oCPL_TIMEOUT, oMM_WR_EN, oMM_RD_EN;
  logic [63:0] oCPL_DATA, oMM_WR_DATA;
  logic [7:0]  oCPL_TAG;
  logic [16:0] oMM_ADDR;
  logic [15:0] oTIMEOUT_CNT;
  typedef struct packed {logic wr; logic [16:0] addr; logic [63:0] data;} mm_t;
  typedef struct packed {logic [63:0] data; logic [7:0] tag; logic to;} cpl_t;
  mm_t  mm_q[$];
  cpl_t cpl_q[$];
  int checks = 0, failures = 0;
  pcie_mm_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .iREQ_V(iREQ_V), .oREQ_RDY(oREQ_RDY), .iREQ_WR(iREQ_WR),
    .iREQ_ADDR(iREQ_ADDR), .iREQ_DATA(iREQ_DATA), .iREQ_TAG(iREQ_TAG), .oCPL_V(oCPL_V),
    .iCPL_RDY(iCPL_RDY), .oCPL_DATA(oCPL_DATA), .oCPL_TAG(oCPL_TAG), .oCPL_TIMEOUT(oCPL_TIMEOUT),
    .oMM_ADDR(oMM_ADDR), .oMM_WR_EN(oMM_WR_EN), .oMM_RD_EN(oMM_RD_EN), .oMM_WR_DATA(oMM_WR_DATA),
    .iMM_RD_DATA(iMM_RD_DATA), .iMM_RD_DATA_V(iMM_RD_DATA_V), .oTIMEOUT_CNT(oTIMEOUT_CNT)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    mm_t  m;
    cpl_t c;
    if (oMM_WR_EN || oMM_RD_EN) begin
      chk("mm_exclusive", {63'd0, oMM_WR_EN & oMM_RD_EN}, 64'd0);
      if (mm_q.size() == 0) chk("mm_unexpected_strobe", {62'd0, oMM_WR_EN, oMM_RD_EN}, 64'd0);
      else begin
        m = mm_q.pop_front();
        chk("mm_wr_en", oMM_WR_EN, m.wr);
        chk("mm_rd_en", oMM_RD_EN, !m.wr);
        chk("mm_addr", oMM_ADDR, m.addr);
        chk("mm_wr_data", oMM_WR_DATA, m.data);
      end
    end
    if (oCPL_V && iCPL_RDY) begin
      if (cpl_q.size() == 0) chk("cpl_unexpected", oCPL_V, 0);
      else begin
        c = cpl_q.pop_front();
        chk("cpl_data", oCPL_DATA, c.data);
        chk("cpl_tag", oCPL_TAG, c.tag);
        chk("cpl_timeout", oCPL_TIMEOUT, c.to);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic wr, input logic [16:0] addr, input logic [63:0] data, input logic [7:0] tag);
    chk("req_rdy_idle", oREQ_RDY, 1);
    mm_q.push_back('{wr, addr, data});
    iREQ_V = 1'b1; iREQ_WR = wr; iREQ_ADDR = addr; iREQ_DATA = data; iREQ_TAG = tag;
    tick;
    iREQ_V = 1'b0;
    chk("issue_strobe", wr ? oMM_WR_EN : oMM_RD_EN, 1);
    chk("req_rdy_busy", oREQ_RDY, 0);
  endtask
  // delay 0 means no return; otherwise valid is driven in WAIT_RD cycle S+delay
  task automatic do_read(input logic [16:0] addr, input logic [7:0] tag, input int delay, input logic [63:0] rdata);
    int last;
    last = (delay == 0) ? 16 : delay;
    cpl_q.push_back(delay == 0 ? '{64'hDEAD_BEEF_DEAD_BEEF, tag, 1'b1} : '{rdata, tag, 1'b0});
    send(1'b0, addr, 64'd0, tag);
    for (int k = 1; k <= last; k++) begin
      tick;
      chk("cpl_not_yet", oCPL_V, 0);
      if (k == delay) begin
        iMM_RD_DATA_V = 1'b1;
        iMM_RD_DATA = rdata;
      end
    end
    tick;
    iMM_RD_DATA_V = 1'b0;
    chk("cpl_v_latency", oCPL_V, 1);
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_req_rdy", oREQ_RDY, 0);
    chk("rst_cpl_v", oCPL_V, 0);
    chk("rst_mm_en", {oMM_WR_EN, oMM_RD_EN}, 0);
    chk("rst_timeout_cnt", oTIMEOUT_CNT, 0);
    rst_n = 1'b1;
    tick;
    chk("rdy_after_release", oREQ_RDY, 1);
    send(1'b1, 17'h00010, 64'h0123_4567_89AB_CDEF, 8'h00);
    chk("wr_addr_t1", oMM_ADDR, 17'h00010);
    tick;
    chk("wr_en_t2", oMM_WR_EN, 0);
    chk("wr_rdy_t2", oREQ_RDY, 1);
    chk("wr_addr_hold", oMM_ADDR, 17'h00010);
    chk("wr_no_cpl", oCPL_V, 0);
    do_read(17'h04000, 8'h5A, 3, 64'hCAFE);
    tick;
    chk("rd_rdy_after_cpl", oREQ_RDY, 1);
    do_read(17'h00100, 8'h01, 0, 64'd0);
    chk("timeout_cnt_1", oTIMEOUT_CNT, 1);
    tick;
    iMM_RD_DATA_V = 1'b1;
    iMM_RD_DATA = 64'hBAD0_BAD0;
    repeat (2) tick;
    iMM_RD_DATA_V = 1'b0;
    chk("late_return_no_cpl", oCPL_V, 0);
    do_read(17'h00101, 8'h02, 16, 64'h0BAD_F00D);
    chk("boundary_cnt_hold", oTIMEOUT_CNT, 1);
    tick;
    iCPL_RDY = 1'b0;
    do_read(17'h00200, 8'h33, 2, 64'h1111);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin iMM_RD_DATA_V = 1'b1; iMM_RD_DATA = 64'h9999; end
      if (i == 5) iMM_RD_DATA_V = 1'b0;
      tick;
      chk("bp_cpl_v", oCPL_V, 1);
      chk("bp_data", oCPL_DATA, 64'h1111);
      chk("bp_tag", oCPL_TAG, 8'h33);
      chk("bp_rdy", oREQ_RDY, 0);
    end
    iCPL_RDY = 1'b1;
    tick;
    chk("bp_release_v", oCPL_V, 0);
    chk("bp_release_rdy", oREQ_RDY, 1);
    send(1'b0, 17'h00222, 64'd0, 8'h77);
    repeat (3) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("wrst_cpl_v", oCPL_V, 0);
    chk("wrst_mm_en", {oMM_WR_EN, oMM_RD_EN}, 0);
    chk("wrst_addr", oMM_ADDR, 0);
    chk("wrst_wr_data", oMM_WR_DATA, 0);
    chk("wrst_cpl_data", oCPL_DATA, 0);
    chk("wrst_cpl_tag", oCPL_TAG, 0);
    chk("wrst_cpl_to", oCPL_TIMEOUT, 0);
    chk("wrst_timeout_cnt", oTIMEOUT_CNT, 0);
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("wrst_no_cpl", oCPL_V, 0);
    end
    do_read(17'h1FFFF, 8'hA5, 5, 64'hFEED_FACE_0000_0001);
    repeat (3) tick;
    chk("mm_q_drained", mm_q.size(), 0);
    chk("cpl_q_drained", cpl_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pcie_mm_master.md
PCIE_MM_MASTER -- requirements
Module: pcie_mm_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of WAIT_RD cycles allowed, legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port iREQ_V, input, 1 bit: PCIe-side request valid.
REQ-005 SHALL have port oREQ_RDY, output, 1 bit: request accepted when iREQ_V and oREQ_RDY are both high.
REQ-006 SHALL have port iREQ_WR, input, 1 bit: 1 = write (posted), 0 = read.
REQ-007 SHALL have port iREQ_ADDR, input, 17 bits: qword address.
REQ-008 SHALL have port iREQ_DATA, input, 64 bits: write data.
REQ-009 SHALL have port iREQ_TAG, input, 8 bits: read tag.
REQ-010 SHALL have port oCPL_V, output, 1 bit: read completion valid.
REQ-011 SHALL have port iCPL_RDY, input, 1 bit: completion consumed when oCPL_V and iCPL_RDY are both high.
REQ-012 SHALL have ports oCPL_DATA (output, 64 bits), oCPL_TAG (output, 8 bits) and oCPL_TIMEOUT (output, 1 bit): completion payload.
REQ-013 SHALL have ports oMM_ADDR (output, 17), oMM_WR_EN (output, 1), oMM_RD_EN (output, 1) and oMM_WR_DATA (output, 64): the MM master bus driven to the address decoder.
REQ-014 SHALL have ports iMM_RD_DATA (input, 64) and iMM_RD_DATA_V (input, 1): MM read return.
REQ-015 SHALL have port oTIMEOUT_CNT, output, 16 bits: count of read timeouts.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_RD and CPL, with at most one MM access outstanding.
REQ-017 SHALL drive oREQ_RDY = 1 only in IDLE.
REQ-018 SHALL, on acceptance in cycle T, register the address, data, WR flag and tag, and enter ISSUE at T+1.
REQ-019 SHALL, in ISSUE, assert exactly one of oMM_WR_EN or oMM_RD_EN for exactly one cycle (T+1), with oMM_ADDR and oMM_WR_DATA holding the captured values.
REQ-020 SHALL drive all MM outputs from registers; oMM_ADDR and oMM_WR_DATA hold their last values outside ISSUE.
REQ-021 SHALL, for a write, go from ISSUE to IDLE, so oREQ_RDY is high at T+2; writes produce no completion.
REQ-022 SHALL, for a read, go from ISSUE to WAIT_RD and clear the timeout counter on entry.
REQ-023 SHALL, in WAIT_RD when iMM_RD_DATA_V = 1, capture iMM_RD_DATA into oCPL_DATA, clear oCPL_TIMEOUT and go to CPL, so oCPL_V = 1 one cycle after the valid.
REQ-024 SHALL, in WAIT_RD when no valid is present, increment the counter; if the counter equals TIMEOUT_CYCLES-1, load oCPL_DATA = 64'hDEAD_BEEF_DEAD_BEEF, set oCPL_TIMEOUT = 1 and go to CPL.
REQ-025 SHALL let valid win when data valid and the timeout condition occur in the same cycle (no timeout).
REQ-026 SHALL hold oCPL_V, oCPL_DATA, oCPL_TAG and oCPL_TIMEOUT stable in CPL until iCPL_RDY = 1, then go to IDLE on the next cycle.
REQ-027 SHALL ignore iMM_RD_DATA_V in any state other than WAIT_RD, including a late return after a timeout; that return SHALL NOT be delivered to the next request.
REQ-028 SHALL increment oTIMEOUT_CNT by 1 per timeout, saturating at 16'hFFFF.
REQ-029 SHALL NOT assert oMM_WR_EN and oMM_RD_EN together under any input sequence.

Reset
REQ-030 SHALL, while rst_n = 0 at a clock edge, set state = IDLE and force oREQ_RDY to 0 during reset (rising to 1 in the first cycle after release).
REQ-031 SHALL, while rst_n = 0 at a clock edge, set oCPL_V, oCPL_TIMEOUT, oMM_WR_EN and oMM_RD_EN to 0, and oMM_ADDR, oMM_WR_DATA, oCPL_DATA, oCPL_TAG, the timeout counter and oTIMEOUT_CNT to 0.
REQ-032 SHALL, on reset asserted mid-transaction, abandon that transaction with no completion and no further MM strobe.

Verification
REQ-033 SHALL cover a write: addr 17'h00010, data 64'h0123_4567_89AB_CDEF accepted at T -> oMM_WR_EN is high only at T+1 with those values, and oREQ_RDY is high at T+2.
REQ-034 SHALL cover a read: tag 8'h5A, addr 17'h04000, slave returns 64'hCAFE at 3 cycles after oMM_RD_EN -> oCPL_V is high with data 64'hCAFE, tag 8'h5A and timeout 0.
REQ-035 SHALL cover a timeout: TIMEOUT_CYCLES = 16, no return, oMM_RD_EN at S -> oCPL_V at S+17 with data 64'hDEAD_BEEF_DEAD_BEEF, oCPL_TIMEOUT = 1 and oTIMEOUT_CNT = 1.
REQ-036 SHALL cover the boundary case: valid in the last WAIT_RD cycle (S+16) -> real data is returned and oCPL_TIMEOUT = 0.
REQ-037 SHALL cover back-pressure: iCPL_RDY held low for 10 cycles -> completion stays stable, oREQ_RDY stays 0, and a late stray iMM_RD_DATA_V is ignored.
REQ-038 SHALL cover reset in WAIT_RD: rst_n low for 1 cycle -> all outputs are at reset values, no oCPL_V, and a subsequent read completes normally.
